pin_debounce: RTL

//   Input conditioner for a raw board pin (e.g. PIN_1 on the TinyFPGA BX, button or jumper).

---
 rtl/pin_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/pin_debounce.sv
// rtl/pin_debounce.sv - pin synchroniser and debouncer with level, edge pulses, toggle and busy flag
module pin_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16000,
    parameter logic INIT_LEVEL      = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic PIN_IN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL,
    output logic TOGGLE,
    output logic BUSY
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, QUAL} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              level_q, level_n;
    logic              rise_q, rise_n;
    logic              fall_q, fall_n;
    logic              toggle_q, toggle_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PIN_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            level_q  <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            level_q  <= level_n;
            rise_q   <= rise_n;
            fall_q   <= fall_n;
            toggle_q <= toggle_n;
        end
    end

    // Any sample matching the current level aborts qualification; no partial credit is kept.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        level_n  = level_q;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        toggle_n = toggle_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (s != level_q) begin
                    cnt_n   = CNT_W'(1);
                    state_n = QUAL;
                end
            end
            QUAL: begin
                if (s == level_q) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_MAX) begin
                    level_n = s;
                    cnt_n   = '0;
                    state_n = IDLE;
                    rise_n  = s;
                    fall_n  = ~s;
                    if (s) begin
                        toggle_n = ~toggle_q;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign LEVEL  = level_q;
    assign RISE   = rise_q;
    assign FALL   = fall_q;
    assign TOGGLE = toggle_q;
    assign BUSY   = (state == QUAL);

endmodule
